// File: rtl/alarm_sequencer.sv
// alarm_sequencer
// Debounces the combined security alarm, latches confirmed alarms until
// software acknowledges them, counts confirmed events and sequences a timed
// hard power cut after a system halt request. Every output is a flop.

module alarm_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,   // consecutive high samples to confirm (2..255)
  parameter int GRACE_CYCLES    = 16,  // halt_pending to power_cut delay (1..65535)
  parameter int CNT_W           = 16   // event_count width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             security_alarm,
  input  logic             system_halt,
  input  logic             sw_ack,
  output logic             alarm_irq,
  output logic             alarm_latched,
  output logic             halt_pending,
  output logic             power_cut,
  output logic [CNT_W-1:0] event_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    LATCHED  = 2'd2,
    SHUTDOWN = 2'd3
  } state_t;

  // Terminal counter values, sized to the counter registers.
  localparam logic [7:0]       DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]      GRACE_LAST = 16'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       db_cnt_q;
  logic [7:0]       db_cnt_d;
  logic [15:0]      grace_cnt_q;
  logic [15:0]      grace_cnt_d;

  logic             irq_d;
  logic             latched_d;
  logic             halt_pending_d;
  logic             power_cut_d;
  logic [CNT_W-1:0] event_count_d;
  logic             event_entry;

  // State register, internal counters and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      grace_cnt_q   <= '0;
      alarm_irq     <= 1'b0;
      alarm_latched <= 1'b0;
      halt_pending  <= 1'b0;
      power_cut     <= 1'b0;
      event_count   <= '0;
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      grace_cnt_q   <= grace_cnt_d;
      alarm_irq     <= irq_d;
      alarm_latched <= latched_d;
      halt_pending  <= halt_pending_d;
      power_cut     <= power_cut_d;
      event_count   <= event_count_d;
    end
  end

  // Next-state and counter update; a halt request pre-empts everything
  // except an already running shutdown.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    grace_cnt_d = grace_cnt_q;

    if (state_q != SHUTDOWN && system_halt) begin
      state_d     = SHUTDOWN;
      db_cnt_d    = '0;
      grace_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (security_alarm) begin
            state_d  = DEBOUNCE;
            db_cnt_d = 8'd1;
          end
        end

        DEBOUNCE: begin
          if (!security_alarm) begin
            // Glitch shorter than the debounce window: drop it silently.
            state_d  = IDLE;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d  = LATCHED;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 8'd1;
          end
        end

        LATCHED: begin
          // An acknowledge only clears the latch once the alarm has gone away.
          if (sw_ack && !security_alarm) begin
            state_d = IDLE;
          end
        end

        SHUTDOWN: begin
          // Terminal until reset; the grace counter parks at its last value.
          if (grace_cnt_q != GRACE_LAST) begin
            grace_cnt_d = grace_cnt_q + 16'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    event_entry    = (state_d != state_q) &&
                     (state_d == LATCHED || state_d == SHUTDOWN);
    irq_d          = event_entry;
    latched_d      = (state_d == LATCHED);
    halt_pending_d = (state_d == SHUTDOWN);
    // Sticky: raised one cycle after the grace counter reaches its terminal value.
    power_cut_d    = power_cut ||
                     (state_q == SHUTDOWN && grace_cnt_q == GRACE_LAST);
    event_count_d  = event_count;
    if (event_entry && event_count != CNT_MAX) begin
      event_count_d = event_count + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
// Table-driven vectors for the debounce/latch/ack paths, hand-written
// sequences for halt timing, escalation, async reset and saturation, then
// randomized stimulus against an event-level reference model.

module tb_alarm_sequencer;

  localparam int D = 4;
  localparam int G = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        alarm;
  logic        halt;
  logic        ack;

  logic        irq, lat, hp, cut;
  logic [15:0] cnt;
  logic [1:0]  st;

  logic        irq2, lat2, hp2, cut2;
  logic [1:0]  cnt2;
  logic [1:0]  st2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alarm_sequencer #(.DEBOUNCE_CYCLES(D), .GRACE_CYCLES(G), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .security_alarm(alarm), .system_halt(halt), .sw_ack(ack),
    .alarm_irq(irq), .alarm_latched(lat), .halt_pending(hp), .power_cut(cut),
    .event_count(cnt), .state(st)
  );

  // Narrow-counter instance sharing the same stimulus, to exercise saturation.
  alarm_sequencer #(.DEBOUNCE_CYCLES(D), .GRACE_CYCLES(G), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .security_alarm(alarm), .system_halt(halt), .sw_ack(ack),
    .alarm_irq(irq2), .alarm_latched(lat2), .halt_pending(hp2), .power_cut(cut2),
    .event_count(cnt2), .state(st2)
  );

  // ---------------- reference model ----------------
  // Tracks the length of the current run of high alarm samples, whether an
  // alarm is latched, whether shutdown is active and how many edges ago it
  // began, and the total number of confirmed events.
  int m_run, m_age, m_events;
  bit m_lat, m_shut, m_irq;

  function automatic void model_reset();
    m_run = 0; m_age = 0; m_events = 0;
    m_lat = 0; m_shut = 0; m_irq = 0;
  endfunction

  function automatic void model_step(bit a, bit h, bit k);
    m_irq = 0;
    if (m_shut) begin
      if (m_age < G) m_age++;
    end else if (h) begin
      m_shut = 1; m_age = 0; m_lat = 0; m_run = 0;
      m_events++; m_irq = 1;
    end else if (m_lat) begin
      if (k && !a) m_lat = 0;
    end else if (a) begin
      m_run++;
      if (m_run == D) begin
        m_lat = 1; m_run = 0; m_events++; m_irq = 1;
      end
    end else begin
      m_run = 0;
    end
  endfunction

  function automatic int exp_state();
    if (m_shut) return 3;
    if (m_lat) return 2;
    if (m_run > 0) return 1;
    return 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},   32'(st),   32'(exp_state()));
    check({tag, ".irq"},     32'(irq),  32'(m_irq));
    check({tag, ".latched"}, 32'(lat),  32'(m_lat));
    check({tag, ".halt_p"},  32'(hp),   32'(m_shut));
    check({tag, ".cut"},     32'(cut),  32'(m_shut && m_age >= G));
    check({tag, ".count"},   32'(cnt),  32'(m_events));
    check({tag, ".count2"},  32'(cnt2), 32'((m_events > 3) ? 3 : m_events));
  endtask

  // Called at a falling edge: drive inputs, advance model, wait one cycle.
  task automatic tick(input bit a, input bit h, input bit k);
    alarm = a; halt = h; ack = k;
    model_step(a, h, k);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; alarm = 1'b0; halt = 1'b0; ack = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst.state", 32'(st),  0);
    check("rst.out",   32'({irq, lat, hp, cut}), 0);
    check("rst.count", 32'(cnt), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       a, h, k;
    bit [1:0] st;
    bit       irq, lat, hp, cut;
    int       cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit a, bit h, bit k, bit [1:0] s,
                              bit i, bit l, bit p, bit c, int n);
    vec_t v;
    v.a = a; v.h = h; v.k = k; v.st = s;
    v.irq = i; v.lat = l; v.hp = p; v.cut = c; v.cnt = n;
    return v;
  endfunction

  int irq_seen;

  initial begin
    rst = 1'b1; alarm = 1'b0; halt = 1'b0; ack = 1'b0;

    //                a  h  k  st irq lat hp cut cnt
    // Glitch: three high samples then low.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Confirmed alarm on the fourth high sample, then ack with alarm low.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1));
    // Ack blocked while alarm still high.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 2, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 0, 1, 2, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 2, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 2));
    // Ack in IDLE does nothing.
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 2));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].a, vecs[i].h, vecs[i].k);
      check($sformatf("vec%0d.state", i), 32'(st),  32'(vecs[i].st));
      check($sformatf("vec%0d.out", i),   32'({irq, lat, hp, cut}),
            32'({vecs[i].irq, vecs[i].lat, vecs[i].hp, vecs[i].cut}));
      check($sformatf("vec%0d.count", i), 32'(cnt), 32'(vecs[i].cnt));
    end

    // Halt: one-cycle pulse, power_cut exactly G cycles after halt_pending.
    do_reset();
    tick(0, 1, 1);
    check("halt.entry", 32'({st, irq, lat, hp, cut}), 32'({2'd3, 1'b1, 1'b0, 1'b1, 1'b0}));
    check("halt.count", 32'(cnt), 1);
    for (int i = 1; i < G; i++) begin
      tick(1'($urandom_range(0, 1)), 0, 1);
      check($sformatf("halt.wait%0d", i), 32'({irq, hp, cut}), 32'({1'b0, 1'b1, 1'b0}));
    end
    tick(0, 0, 1);
    check("halt.cut", 32'({st, hp, cut}), 32'({2'd3, 1'b1, 1'b1}));
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 1);
      check_all("halt.hold");
    end

    // Escalation: LATCHED then halt gives two events, then async reset mid-grace.
    do_reset();
    irq_seen = 0;
    for (int i = 0; i < D; i++) begin
      tick(1, 0, 0);
      irq_seen += int'(irq);
    end
    check("esc.latched", 32'({st, lat}), 32'({2'd2, 1'b1}));
    tick(1, 1, 0);
    irq_seen += int'(irq);
    check("esc.shutdown", 32'({st, lat, hp}), 32'({2'd3, 1'b0, 1'b1}));
    check("esc.count", 32'(cnt), 2);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1);
      irq_seen += int'(irq);
      check_all("esc.grace");
    end
    check("esc.irq_pulses", 32'(irq_seen), 2);
    #1 rst = 1'b1;
    #1;
    check("esc.async_rst", 32'({st, irq, lat, hp, cut}), 0);
    check("esc.async_cnt", 32'({cnt, cnt2}), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Simultaneous alarm and halt in IDLE: shutdown only, one event.
    tick(1, 1, 0);
    check("simul.entry", 32'({st, irq, lat}), 32'({2'd3, 1'b1, 1'b0}));
    check("simul.count", 32'(cnt), 1);
    tick(1, 0, 0);
    check_all("simul.next");

    // Saturation: five confirmed alarm/ack rounds.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < D; i++) tick(1, 0, 0);
      tick(0, 0, 1);
    end
    check("sat.count2", 32'(cnt2), 3);
    check("sat.count",  32'(cnt), 5);
    check("sat.state",  32'(st), 0);

    // Randomized stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit a, h, k;
      if (m_shut && m_age >= G + 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
        continue;
      end
      a = ($urandom_range(0, 9) < 7);
      h = ($urandom_range(0, 149) == 0);
      k = ($urandom_range(0, 2) == 0);
      tick(a, h, k);
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
